warp_sched: RTL
===============

WARP_SCHED -- requirements
Module: warp_sched

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, giving the number of hardware warps (range 1-16).
REQ-002 SHALL have parameter PC_W, default 32, giving the PC width.
REQ-003 SHALL have parameter PC_STEP, default 1, giving the PC increment per retired non-redirect instruction.
REQ-004 SHALL define derived width WID_W = max(1, clog2(NUM_WARPS)).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port launch_valid, input, 1 bit: kernel launch request.
REQ-008 SHALL have port launch_mask, input, NUM_WARPS bits: warps to start.
REQ-009 SHALL have port launch_pc, input, PC_W bits: start PC for all launched warps.
REQ-010 SHALL have port issue_valid, output, 1 bit: issue slot holds a warp.
REQ-011 SHALL have port issue_ready, input, 1 bit: fetch/IF stage accepts.
REQ-012 SHALL have port issue_pc, output, PC_W bits: PC to fetch.
REQ-013 SHALL have port issue_wid, output, WID_W bits: warp id, also the TID writeback source.
REQ-014 SHALL have port retire_valid, input, 1 bit: an instruction completed in WB/EX.
REQ-015 SHALL have port retire_wid, input, WID_W bits: warp of the retiring instruction.
REQ-016 SHALL have port retire_redirect, input, 1 bit: branch taken.
REQ-017 SHALL have port retire_target, input, PC_W bits: branch target.
REQ-018 SHALL have port retire_halt, input, 1 bit: HALT retired.
REQ-019 SHALL have port busy, output, 1 bit: some warp is not IDLE/DONE.
REQ-020 SHALL have port all_done, output, 1 bit: equals ~busy.

Function
REQ-021 SHALL keep per warp a PC register (PC_W) and a state in {IDLE, READY, SLOT, WAIT, DONE}.
REQ-022 SHALL hold at most one in-flight instruction per warp; a warp is selectable only in READY.
REQ-023 SHALL register the issue outputs; issue_valid/issue_pc/issue_wid SHALL remain stable while issue_valid=1 and issue_ready=0.
REQ-024 SHALL treat the slot as loadable when issue_valid=0 or (issue_valid=1 and issue_ready=1).
REQ-025 SHALL, when loadable, select the first READY warp searching from rr_ptr upward modulo NUM_WARPS, load its id/PC, move it READY->SLOT, and set issue_valid=1; with no READY warp, issue_valid SHALL become 0.
REQ-026 SHALL, on handshake, move the slotted warp SLOT->WAIT and set rr_ptr to (issued wid + 1) mod NUM_WARPS.
REQ-027 SHALL give a 1-cycle latency from a warp becoming READY (registered) to issue_valid with that warp, when the slot is loadable.
REQ-028 SHALL, on retire_valid for a warp in WAIT, take the following priority: retire_halt -> DONE (PC unchanged); else retire_redirect -> PC=retire_target, READY; else PC=PC+PC_STEP (wrap modulo 2^PC_W), READY.
REQ-029 SHALL ignore retire_valid for a warp not in WAIT, or with retire_wid >= NUM_WARPS.
REQ-030 SHALL make a warp that retires in cycle N selectable no earlier than the slot load at edge N+1.
REQ-031 SHALL accept launch_valid only when busy=0 and the slot is empty: masked warps -> READY with PC=launch_pc; unmasked warps -> IDLE.
REQ-032 SHALL ignore launch_valid while busy=1; launch_mask=0 SHALL leave all warps IDLE and busy=0.
REQ-033 SHALL compute busy combinationally as the OR over warps of state in {READY, SLOT, WAIT}.

Reset
REQ-034 SHALL, while rst=1 at a clock edge, set all warps IDLE, all PCs 0, rr_ptr=0, issue_valid=0, issue_pc=0, issue_wid=0; busy=0, all_done=1.
REQ-035 SHALL give rst priority over launch, retire and handshake in the same cycle, discarding any in-flight slot.

Verification
REQ-036 Bench SHALL check: NUM_WARPS=4, reset, launch mask 1111 pc 0x10, issue_ready=1, no retire -> issues w0,w1,w2,w3 each pc 0x10 on four consecutive cycles, then issue_valid=0, busy=1.
REQ-037 Bench SHALL check: after REQ-036, retire w1 without redirect -> next issue w1 pc 0x11; retire w2 redirect target 0x40 -> w2 issued with pc 0x40.
REQ-038 Bench SHALL check: issue_ready=0 for 3 cycles with w0 in the slot while w3 retires -> slot holds w0/pc unchanged; after ready=1, w0 is accepted, then w3 issues.
REQ-039 Bench SHALL check: halt-retire all four warps -> all_done=1 on the cycle after the last halt; a launch during busy=1 (mask 0001, pc 0x80) produces no issue.
REQ-040 Bench SHALL check: rr fairness with warps 0 and 2 retiring every cycle -> issue_wid alternates 0,2,0,2.
REQ-041 Bench SHALL check: rst asserted while w1 is in the slot and w3 is in WAIT -> next cycle issue_valid=0, busy=0, and a late retire for w3 is ignored.

Source files
------------

// File: rtl/warp_sched.sv
// warp_sched: round-robin warp scheduler with one registered issue slot and one in-flight instruction per warp
//   clk, rst            : clock, synchronous active-high reset
//   launch_valid/mask/pc: start masked warps at launch_pc when idle and the slot is empty
//   issue_valid/ready   : registered issue slot handshake carrying issue_pc and issue_wid
//   retire_*            : completion of a warp's instruction (halt, redirect or sequential PC)
//   busy, all_done      : some warp still active / none active
module warp_sched #(
    parameter int NUM_WARPS = 4,
    parameter int PC_W = 32,
    parameter int PC_STEP = 1,
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             launch_valid,
    input  logic [NUM_WARPS-1:0] launch_mask,
    input  logic [PC_W-1:0]  launch_pc,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [PC_W-1:0]  issue_pc,
    output logic [WID_W-1:0] issue_wid,
    input  logic             retire_valid,
    input  logic [WID_W-1:0] retire_wid,
    input  logic             retire_redirect,
    input  logic [PC_W-1:0]  retire_target,
    input  logic             retire_halt,
    output logic             busy,
    output logic             all_done
);
    typedef enum logic [2:0] {IDLE, READY, SLOT, WAIT, DONE} wstate_t;

    wstate_t          st_q [NUM_WARPS];
    wstate_t          st_d [NUM_WARPS];
    logic [PC_W-1:0]  pc_q [NUM_WARPS];
    logic [PC_W-1:0]  pc_d [NUM_WARPS];
    logic [WID_W-1:0] cand [NUM_WARPS];
    logic [WID_W-1:0] rr_ptr, rr_d, sel, issue_wid_d;
    logic [PC_W-1:0]  issue_pc_d;
    logic             issue_valid_d, hs, load, found;

    always_comb begin
        busy = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++)
            busy = busy | (st_q[w] == READY) | (st_q[w] == SLOT) | (st_q[w] == WAIT);
        all_done = ~busy;
    end

    always_comb begin
        hs = issue_valid && issue_ready;
        load = !issue_valid || issue_ready;
        // Searching from the post-handshake pointer lets the warp just issued yield to the others.
        rr_d = hs ? WID_W'((int'(issue_wid) + 1) % NUM_WARPS) : rr_ptr;
        st_d = st_q;
        pc_d = pc_q;
        issue_valid_d = issue_valid;
        issue_pc_d = issue_pc;
        issue_wid_d = issue_wid;
        found = 1'b0;
        sel = '0;
        for (int k = 0; k < NUM_WARPS; k++)
            cand[k] = WID_W'((int'(rr_d) + k) % NUM_WARPS);
        // Scan backwards so the closest READY warp to the pointer is written last.
        for (int k = NUM_WARPS - 1; k >= 0; k--)
            if (st_q[cand[k]] == READY) begin
                found = 1'b1;
                sel = cand[k];
            end
        if (hs)
            st_d[issue_wid] = WAIT;
        for (int w = 0; w < NUM_WARPS; w++)
            if (retire_valid && retire_wid == WID_W'(w) && st_q[w] == WAIT) begin
                st_d[w] = retire_halt ? DONE : READY;
                pc_d[w] = retire_halt ? pc_q[w] : retire_redirect ? retire_target : pc_q[w] + PC_W'(PC_STEP);
            end
        if (load) begin
            issue_valid_d = found;
            if (found) begin
                issue_pc_d = pc_q[sel];
                issue_wid_d = sel;
                st_d[sel] = SLOT;
            end
        end
        if (launch_valid && !busy && !issue_valid)
            for (int w = 0; w < NUM_WARPS; w++) begin
                st_d[w] = launch_mask[w] ? READY : IDLE;
                pc_d[w] = launch_mask[w] ? launch_pc : pc_q[w];
            end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                st_q[w] <= IDLE;
                pc_q[w] <= '0;
            end
            rr_ptr <= '0;
            issue_valid <= 1'b0;
            issue_pc <= '0;
            issue_wid <= '0;
        end else begin
            st_q <= st_d;
            pc_q <= pc_d;
            rr_ptr <= rr_d;
            issue_valid <= issue_valid_d;
            issue_pc <= issue_pc_d;
            issue_wid <= issue_wid_d;
        end
    end
endmodule
